chunk_sequencer: RTL and testbench
==================================

CHUNK_SEQUENCER -- requirements
Module: chunk_sequencer

Interface
REQ-001 Parameter BUF_SIZE, default 9: bus control buffer width in bits.
REQ-002 Parameter CHUNK_SIZE_WIDTH, default $clog2(BUF_SIZE+1): chunk size field width.
REQ-003 Parameter STEPS, default 8: script table depth. STEP_W = $clog2(STEPS).
REQ-004 sys_clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  arms script execution.
REQ-007 comm_active  in  1  bus session active, from bus control.
REQ-008 bus_ready  in  1  current chunk complete, from bus control.
REQ-009 real_mosi_data  in  BUF_SIZE  captured MOSI bits of the current chunk; LSB = last bit received.
REQ-010 cfg_we  in  1  table write strobe.
REQ-011 cfg_addr  in  STEP_W  table entry index.
REQ-012 cfg_size  in  CHUNK_SIZE_WIDTH  chunk length in bits; 0 = finish.
REQ-013 cfg_fake  in  1  substitute MISO during this chunk.
REQ-014 cfg_data  in  BUF_SIZE  fake MISO data, MSB-aligned.
REQ-015 cfg_match_en  in  1 / cfg_match_val  in  BUF_SIZE  continue only on a MOSI match.
REQ-016 cfg_last  in  1  finish after this step.
REQ-017 cmd_next_chunk, cmd_finish  out  1  one-cycle command pulses to bus control.
REQ-018 next_chunk_size  out  CHUNK_SIZE_WIDTH; fake_miso_select  out  1; fake_miso_data  out  BUF_SIZE.
REQ-019 busy  out  1  (state != IDLE); cur_step  out  STEP_W; cfg_err  out  1  one-cycle pulse on a rejected write; aborted  out  1  sticky flag for a session killed mid-script.

Function
REQ-020 States: IDLE, ISSUE, WAIT, FIN_ISSUE, FIN_WAIT. All outputs are registered.
REQ-021 armed flag behaviour:
- Set when enable=1 and comm_active=0 in IDLE or FIN_WAIT.
- Cleared when enable=0 or on session start.
- A session starts only in IDLE with armed=1 and comm_active=1, so no session is ever joined midway.
REQ-022 Session start:
- cur_step<=0, aborted<=0.
- Step 0 size!=0: load next_chunk_size, fake_miso_select and fake_miso_data from step 0, cmd_next_chunk<=1, go to ISSUE.
- Step 0 size==0: next_chunk_size<=0, fake_miso_select<=0, cmd_finish<=1, go to FIN_ISSUE.
REQ-023 ISSUE: cmd_next_chunk<=0, go to WAIT. Each command pulse is exactly 1 cycle.
REQ-024 WAIT with bus_ready=1, finish case:
- Condition: step last=1, OR match_en=1 with mismatch, OR cur_step==STEPS-1, OR next step size==0.
- Action: next_chunk_size<=0, fake_miso_select<=0, cmd_finish<=1, go to FIN_ISSUE.
REQ-025 WAIT with bus_ready=1, otherwise: cur_step+1, load that step's fields, cmd_next_chunk<=1, go to ISSUE. cur_step never wraps.
REQ-026 Match rule: real_mosi_data[size-1:0] == match_val[size-1:0], using the current step's size; bits above size are ignored.
REQ-027 WAIT with bus_ready=0 and comm_active=0: aborted<=1, go to FIN_WAIT, no cmd_finish. If bus_ready and a comm_active drop coincide, bus_ready wins.
REQ-028 FIN_ISSUE: cmd_finish<=0, go to FIN_WAIT.
REQ-029 FIN_WAIT: when comm_active=0, clear next_chunk_size, fake_miso_select and fake_miso_data, cur_step<=0, go to IDLE.
REQ-030 Latency: one cycle from sampled comm_active or bus_ready to the resulting command pulse.
REQ-031 Table writes:
- cfg_we is honoured only in IDLE; otherwise the write is ignored and cfg_err pulses the next cycle.
- A write coinciding with session start is committed, but step 0 uses the pre-write contents.
REQ-032 Table entry fields: {size, fake, data, match_en, match_val, last}.

Reset
REQ-033 rst from any state: next edge gives state IDLE, all outputs 0, armed=0, aborted=0, cur_step=0. An in-flight pulse is dropped and no cmd_finish is issued.
REQ-034 rst sets every table entry to size 0, fake 0, match_en 0, last 1, data 0, match_val 0. The default script is an immediate finish (pure forward).
REQ-035 While rst=1, cfg_we is ignored and cfg_err stays 0.

Verification
REQ-036 Default table; enable=1; comm_active low then high -> single 1-cycle cmd_finish, next_chunk_size 0, cmd_next_chunk never asserted.
REQ-037 Read script, MOSI 3'b110:
- Script: step0 size 3, match 3'b110; step1 size 9; step2 size 8, fake, data 9'h048, last.
- Required: pulses with sizes 3, 9, 8; fake_miso_select=1 only in step2 with data 9'h048; then cmd_finish.
REQ-038 Same script, MOSI 3'b101 -> cmd_finish right after step0, fake_miso_select never 1, aborted=0.
REQ-039 Kill cases:
- comm_active drops in step1 WAIT -> no cmd_finish, aborted=1, IDLE once low.
- comm_active drop coinciding with bus_ready -> step2 pulse still issued.
REQ-040 Arming and config:
- enable rises while comm_active=1 -> no commands until comm_active goes low then high.
- cfg_we while busy -> cfg_err for 1 cycle, table unchanged.
REQ-041 rst asserted in step1 WAIT -> all outputs 0 next cycle, busy=0, table at default.

Source files
------------

// File: rtl/chunk_sequencer.sv
// Script-driven chunk sequencer: walks a step table, issuing one-cycle next-chunk / finish
// commands to bus control and optionally substituting MISO data for individual chunks.
module chunk_sequencer #(
   parameter int BUF_SIZE         = 9,
   parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
   parameter int STEPS            = 8,
   localparam int STEP_W          = $clog2(STEPS)
) (
   input  logic                        sys_clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        comm_active,
   input  logic                        bus_ready,
   input  logic [BUF_SIZE-1:0]         real_mosi_data,
   input  logic                        cfg_we,
   input  logic [STEP_W-1:0]           cfg_addr,
   input  logic [CHUNK_SIZE_WIDTH-1:0] cfg_size,
   input  logic                        cfg_fake,
   input  logic [BUF_SIZE-1:0]         cfg_data,
   input  logic                        cfg_match_en,
   input  logic [BUF_SIZE-1:0]         cfg_match_val,
   input  logic                        cfg_last,
   output logic                        cmd_next_chunk,
   output logic                        cmd_finish,
   output logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
   output logic                        fake_miso_select,
   output logic [BUF_SIZE-1:0]         fake_miso_data,
   output logic                        busy,
   output logic [STEP_W-1:0]           cur_step,
   output logic                        cfg_err,
   output logic                        aborted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FIN_ISSUE,
      S_FIN_WAIT
   } state_t;

   state_t state, state_nxt;
   logic   armed;

   logic [CHUNK_SIZE_WIDTH-1:0] tbl_size  [STEPS];
   logic                        tbl_fake  [STEPS];
   logic [BUF_SIZE-1:0]         tbl_data  [STEPS];
   logic                        tbl_men   [STEPS];
   logic [BUF_SIZE-1:0]         tbl_mval  [STEPS];
   logic                        tbl_last  [STEPS];

   logic                        start;
   logic [STEP_W-1:0]           step_inc;
   logic [BUF_SIZE-1:0]         size_mask;
   logic                        mismatch;
   logic                        fin_cond;

   logic                        next_chunk_n;
   logic                        finish_n;
   logic [CHUNK_SIZE_WIDTH-1:0] size_n;
   logic                        fsel_n;
   logic [BUF_SIZE-1:0]         fdat_n;
   logic [STEP_W-1:0]           step_n;
   logic                        aborted_n;

   // A session is only ever entered from IDLE after seeing the bus idle while armed.
   assign start    = (state == S_IDLE) && armed && comm_active;
   assign step_inc = cur_step + 1'b1;

   always_comb begin
      size_mask = '0;
      for (int i = 0; i < BUF_SIZE; i++) begin
         size_mask[i] = (i < int'(tbl_size[cur_step]));
      end
   end

   assign mismatch = |((real_mosi_data ^ tbl_mval[cur_step]) & size_mask);
   assign fin_cond = tbl_last[cur_step]
                  || (tbl_men[cur_step] && mismatch)
                  || (cur_step == STEP_W'(STEPS - 1))
                  || (tbl_size[step_inc] == '0);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state            <= S_IDLE;
         armed            <= 1'b0;
         cmd_next_chunk   <= 1'b0;
         cmd_finish       <= 1'b0;
         next_chunk_size  <= '0;
         fake_miso_select <= 1'b0;
         fake_miso_data   <= '0;
         busy             <= 1'b0;
         cur_step         <= '0;
         cfg_err          <= 1'b0;
         aborted          <= 1'b0;
         for (int i = 0; i < STEPS; i++) begin
            tbl_size[i] <= '0;
            tbl_fake[i] <= 1'b0;
            tbl_data[i] <= '0;
            tbl_men[i]  <= 1'b0;
            tbl_mval[i] <= '0;
            tbl_last[i] <= 1'b1;
         end
      end else begin
         state            <= state_nxt;
         cmd_next_chunk   <= next_chunk_n;
         cmd_finish       <= finish_n;
         next_chunk_size  <= size_n;
         fake_miso_select <= fsel_n;
         fake_miso_data   <= fdat_n;
         busy             <= (state_nxt != S_IDLE);
         cur_step         <= step_n;
         aborted          <= aborted_n;
         cfg_err          <= cfg_we && (state != S_IDLE);

         if (!enable || start) begin
            armed <= 1'b0;
         end else if (((state == S_IDLE) || (state == S_FIN_WAIT)) && !comm_active) begin
            armed <= 1'b1;
         end

         // The start cycle reads the old entry; the write lands for later sessions.
         if (cfg_we && (state == S_IDLE)) begin
            tbl_size[cfg_addr] <= cfg_size;
            tbl_fake[cfg_addr] <= cfg_fake;
            tbl_data[cfg_addr] <= cfg_data;
            tbl_men[cfg_addr]  <= cfg_match_en;
            tbl_mval[cfg_addr] <= cfg_match_val;
            tbl_last[cfg_addr] <= cfg_last;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (tbl_size[0] != '0) ? S_ISSUE : S_FIN_ISSUE;
         end
         S_ISSUE:     state_nxt = S_WAIT;
         S_WAIT: begin
            if (bus_ready)        state_nxt = fin_cond ? S_FIN_ISSUE : S_ISSUE;
            else if (!comm_active) state_nxt = S_FIN_WAIT;
         end
         S_FIN_ISSUE: state_nxt = S_FIN_WAIT;
         S_FIN_WAIT: begin
            if (!comm_active) state_nxt = S_IDLE;
         end
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      next_chunk_n = 1'b0;
      finish_n     = 1'b0;
      size_n       = next_chunk_size;
      fsel_n       = fake_miso_select;
      fdat_n       = fake_miso_data;
      step_n       = cur_step;
      aborted_n    = aborted;
      case (state)
         S_IDLE: begin
            if (start) begin
               step_n    = '0;
               aborted_n = 1'b0;
               if (tbl_size[0] != '0) begin
                  size_n       = tbl_size[0];
                  fsel_n       = tbl_fake[0];
                  fdat_n       = tbl_data[0];
                  next_chunk_n = 1'b1;
               end else begin
                  size_n   = '0;
                  fsel_n   = 1'b0;
                  finish_n = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (bus_ready) begin
               if (fin_cond) begin
                  size_n   = '0;
                  fsel_n   = 1'b0;
                  finish_n = 1'b1;
               end else begin
                  step_n       = step_inc;
                  size_n       = tbl_size[step_inc];
                  fsel_n       = tbl_fake[step_inc];
                  fdat_n       = tbl_data[step_inc];
                  next_chunk_n = 1'b1;
               end
            end else if (!comm_active) begin
               aborted_n = 1'b1;
            end
         end
         S_FIN_WAIT: begin
            if (!comm_active) begin
               size_n = '0;
               fsel_n = 1'b0;
               fdat_n = '0;
               step_n = '0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_chunk_sequencer.sv
// Bench for chunk_sequencer: directed scenarios plus random scripts checked against a step-list model.
module tb_chunk_sequencer;
   localparam int BS = 9;
   localparam int CW = 4;
   localparam int ST = 8;
   localparam int SW = 3;

   logic          sys_clk = 1'b0;
   logic          rst, enable, comm_active, bus_ready;
   logic [BS-1:0] real_mosi_data;
   logic          cfg_we;
   logic [SW-1:0] cfg_addr;
   logic [CW-1:0] cfg_size;
   logic          cfg_fake;
   logic [BS-1:0] cfg_data;
   logic          cfg_match_en;
   logic [BS-1:0] cfg_match_val;
   logic          cfg_last;
   logic          cmd_next_chunk, cmd_finish;
   logic [CW-1:0] next_chunk_size;
   logic          fake_miso_select;
   logic [BS-1:0] fake_miso_data;
   logic          busy;
   logic [SW-1:0] cur_step;
   logic          cfg_err, aborted;

   int tests = 0;
   int fails = 0;

   int m_size [ST];
   bit m_fake [ST];
   int m_data [ST];
   bit m_men  [ST];
   int m_mval [ST];
   bit m_last [ST];
   int m_mosi [ST];

   int q_sz[$], q_fk[$], q_dt[$], q_st[$];
   int fin_cnt  = 0;
   int fin_bad  = 0;
   int wide_err = 0;
   bit prev_nc  = 1'b0;
   bit prev_fn  = 1'b0;

   chunk_sequencer #(.BUF_SIZE(BS), .CHUNK_SIZE_WIDTH(CW), .STEPS(ST)) dut (
      .sys_clk(sys_clk), .rst(rst), .enable(enable), .comm_active(comm_active),
      .bus_ready(bus_ready), .real_mosi_data(real_mosi_data), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_size(cfg_size), .cfg_fake(cfg_fake), .cfg_data(cfg_data),
      .cfg_match_en(cfg_match_en), .cfg_match_val(cfg_match_val), .cfg_last(cfg_last),
      .cmd_next_chunk(cmd_next_chunk), .cmd_finish(cmd_finish),
      .next_chunk_size(next_chunk_size), .fake_miso_select(fake_miso_select),
      .fake_miso_data(fake_miso_data), .busy(busy), .cur_step(cur_step),
      .cfg_err(cfg_err), .aborted(aborted)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #3000000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   // Record every command pulse seen by bus control.
   always @(negedge sys_clk) begin
      if (cmd_next_chunk) begin
         q_sz.push_back(int'(next_chunk_size));
         q_fk.push_back(int'(fake_miso_select));
         q_dt.push_back(int'(fake_miso_data));
         q_st.push_back(int'(cur_step));
      end
      if (cmd_finish) begin
         fin_cnt++;
         if (next_chunk_size != 0 || fake_miso_select) fin_bad++;
      end
      if ((cmd_next_chunk && prev_nc) || (cmd_finish && prev_fn)) wide_err++;
      prev_nc = cmd_next_chunk;
      prev_fn = cmd_finish;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      q_sz.delete(); q_fk.delete(); q_dt.delete(); q_st.delete();
      fin_cnt = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < ST; i++) begin
         m_size[i] = 0; m_fake[i] = 0; m_data[i] = 0;
         m_men[i] = 0;  m_mval[i] = 0; m_last[i] = 1; m_mosi[i] = 0;
      end
   endtask

   task automatic write_step(input int a, input int sz, input bit fk, input int dt,
                             input bit men, input int mv, input bit lst);
      cfg_we = 1'b1; cfg_addr = a[SW-1:0]; cfg_size = sz[CW-1:0]; cfg_fake = fk;
      cfg_data = dt[BS-1:0]; cfg_match_en = men; cfg_match_val = mv[BS-1:0]; cfg_last = lst;
      @(negedge sys_clk);
      cfg_we = 1'b0;
      chk("cfg_err_idle", cfg_err, 0);
      m_size[a] = sz; m_fake[a] = fk; m_data[a] = dt;
      m_men[a] = men; m_mval[a] = mv; m_last[a] = lst;
   endtask

   task automatic arm();
      enable = 1'b1; comm_active = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   // Acts as bus control for one session; kill_step<0 means the session runs to completion.
   task automatic run_session(input int kill_step, input bit kill_rdy);
      int step;
      int guard;
      bit done;
      step = 0; guard = 0; done = 1'b0;
      clear_mon();
      comm_active = 1'b1;
      @(negedge sys_clk);
      chk("start_latency", cmd_next_chunk | cmd_finish, 1);
      while (!done && guard < 200) begin
         guard++;
         if (cmd_finish) begin
            repeat ($urandom_range(0, 2)) @(negedge sys_clk);
            comm_active = 1'b0;
            done = 1'b1;
         end else if (cmd_next_chunk) begin
            repeat ($urandom_range(1, 3)) @(negedge sys_clk);
            real_mosi_data = m_mosi[step][BS-1:0];
            if (step == kill_step) begin
               comm_active = 1'b0;
               bus_ready = kill_rdy;
               done = 1'b1;
               @(negedge sys_clk);
               bus_ready = 1'b0;
            end else begin
               bus_ready = 1'b1;
               @(negedge sys_clk);
               bus_ready = 1'b0;
               chk("ready_latency", cmd_next_chunk | cmd_finish, 1);
            end
            step++;
         end else begin
            @(negedge sys_clk);
         end
      end
      chk("session_done", done, 1);
      comm_active = 1'b0;
      guard = 0;
      while (busy && guard < 40) begin
         @(negedge sys_clk);
         guard++;
      end
      chk("idle_after_session", busy, 0);
   endtask

   // Reference: list the steps whose chunks are issued, then how the session ends.
   task automatic check_session(input string tag, input int kill_step, input bit kill_rdy);
      int exp_st[$];
      bit exp_fin, exp_abort, ended, stop;
      int s, msk;
      exp_fin = 0; exp_abort = 0; ended = 0; s = 0;
      if (m_size[0] == 0) begin
         exp_fin = 1;
         ended = 1;
      end
      while (!ended) begin
         exp_st.push_back(s);
         if (s == kill_step && !kill_rdy) begin
            exp_abort = 1; ended = 1;
         end else begin
            msk = (1 << m_size[s]) - 1;
            stop = m_last[s] || (m_men[s] && (((m_mosi[s] ^ m_mval[s]) & msk) != 0))
                || (s == ST - 1) || (m_size[s + 1] == 0);
            if (stop) begin
               exp_fin = 1; ended = 1;
            end else if (s == kill_step) begin
               exp_st.push_back(s + 1);
               exp_abort = 1; ended = 1;
            end
            s++;
         end
      end
      chk({tag, "_npulses"}, q_sz.size(), exp_st.size());
      for (int i = 0; i < exp_st.size() && i < q_sz.size(); i++) begin
         chk({tag, "_size"}, q_sz[i], m_size[exp_st[i]]);
         chk({tag, "_fake"}, q_fk[i], m_fake[exp_st[i]]);
         chk({tag, "_data"}, q_dt[i], m_data[exp_st[i]]);
         chk({tag, "_step"}, q_st[i], exp_st[i]);
      end
      chk({tag, "_finish"}, fin_cnt, exp_fin);
      chk({tag, "_aborted"}, aborted, exp_abort);
   endtask

   task automatic load_read_script();
      write_step(0, 3, 0, 0, 1, 3'b110, 0);
      write_step(1, 9, 0, 0, 0, 0, 0);
      write_step(2, 8, 1, 9'h048, 0, 0, 1);
   endtask

   initial begin
      int guard;
      int kill, msk, mv, sz;
      bit krdy;
      rst = 1'b1; enable = 1'b0; comm_active = 1'b0; bus_ready = 1'b0;
      real_mosi_data = '0; cfg_we = 1'b1; cfg_addr = '0; cfg_size = 4'd5;
      cfg_fake = 1'b1; cfg_data = '1; cfg_match_en = 1'b0; cfg_match_val = '0; cfg_last = 1'b0;
      model_reset();

      // Reset state; writes during reset are dropped silently.
      @(negedge sys_clk);
      chk("rst_cfg_err_a", cfg_err, 0);
      @(negedge sys_clk);
      chk("rst_cfg_err_b", cfg_err, 0);
      cfg_we = 1'b0; rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_next_chunk", cmd_next_chunk, 0);
      chk("rst_finish", cmd_finish, 0);
      chk("rst_size", next_chunk_size, 0);
      chk("rst_fsel", fake_miso_select, 0);
      chk("rst_fdat", fake_miso_data, 0);
      chk("rst_step", cur_step, 0);
      chk("rst_aborted", aborted, 0);

      // Default table: immediate finish.
      arm();
      run_session(-1, 0);
      check_session("default", -1, 0);

      // Read script with matching MOSI.
      load_read_script();
      m_mosi[0] = 3'b110;
      arm();
      run_session(-1, 0);
      check_session("read110", -1, 0);
      chk("read110_sz0", q_sz[0], 3);
      chk("read110_sz1", q_sz[1], 9);
      chk("read110_sz2", q_sz[2], 8);
      chk("read110_fk2", q_fk[2], 1);
      chk("read110_dt2", q_dt[2], 9'h048);

      // Mismatch at step 0.
      m_mosi[0] = 3'b101;
      arm();
      run_session(-1, 0);
      check_session("read101", -1, 0);
      chk("read101_npulses", q_sz.size(), 1);

      // Kill in step 1 wait, then kill coinciding with bus_ready.
      m_mosi[0] = 3'b110;
      arm();
      run_session(1, 0);
      check_session("kill1", 1, 0);
      arm();
      run_session(1, 1);
      check_session("kill1_rdy", 1, 1);
      chk("kill1_rdy_step2", q_sz.size(), 3);

      // Enable rising mid-session must not join it.
      enable = 1'b0;
      @(negedge sys_clk);
      clear_mon();
      comm_active = 1'b1;
      @(negedge sys_clk);
      enable = 1'b1;
      repeat (8) @(negedge sys_clk);
      chk("late_arm_busy", busy, 0);
      chk("late_arm_cmds", q_sz.size() + fin_cnt, 0);
      arm();
      run_session(-1, 0);
      check_session("after_rearm", -1, 0);

      // Write while busy is rejected.
      arm();
      clear_mon();
      comm_active = 1'b1;
      guard = 0;
      do begin
         @(negedge sys_clk);
         guard++;
      end while (!busy && guard < 20);
      chk("busy_seen", busy, 1);
      cfg_we = 1'b1; cfg_addr = '0; cfg_size = 4'd5; cfg_fake = 1'b1; cfg_last = 1'b1;
      @(negedge sys_clk);
      cfg_we = 1'b0;
      chk("cfg_err_pulse", cfg_err, 1);
      @(negedge sys_clk);
      chk("cfg_err_one_cycle", cfg_err, 0);
      comm_active = 1'b0;
      repeat (4) @(negedge sys_clk);
      arm();
      run_session(-1, 0);
      check_session("table_unchanged", -1, 0);

      // Reset while waiting on step 1.
      arm();
      clear_mon();
      comm_active = 1'b1;
      @(negedge sys_clk);
      @(negedge sys_clk);
      real_mosi_data = 9'b110;
      bus_ready = 1'b1;
      @(negedge sys_clk);
      bus_ready = 1'b0;
      @(negedge sys_clk);
      chk("pre_rst_step", cur_step, 1);
      rst = 1'b1;
      @(negedge sys_clk);
      rst = 1'b0;
      model_reset();
      chk("midrst_busy", busy, 0);
      chk("midrst_next_chunk", cmd_next_chunk, 0);
      chk("midrst_finish", cmd_finish, 0);
      chk("midrst_size", next_chunk_size, 0);
      chk("midrst_fsel", fake_miso_select, 0);
      chk("midrst_fdat", fake_miso_data, 0);
      chk("midrst_step", cur_step, 0);
      repeat (3) @(negedge sys_clk);
      chk("midrst_no_finish", fin_cnt, 0);
      chk("midrst_no_restart", busy, 0);
      arm();
      run_session(-1, 0);
      check_session("post_rst_default", -1, 0);

      // Random scripts against the model.
      for (int it = 0; it < 24; it++) begin
         for (int s = 0; s < ST; s++) begin
            sz = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9);
            mv = $urandom_range(0, 511);
            write_step(s, sz, 1'($urandom_range(0, 1)), $urandom_range(0, 511),
                       1'($urandom_range(0, 1)), mv, ($urandom_range(0, 5) == 0));
            msk = (1 << sz) - 1;
            m_mosi[s] = $urandom_range(0, 1) ? ((mv & msk) | ($urandom_range(0, 511) & ~msk & 511))
                                             : $urandom_range(0, 511);
         end
         kill = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ST - 1) : -1;
         krdy = 1'($urandom_range(0, 1));
         arm();
         run_session(kill, krdy);
         check_session("random", kill, krdy);
      end

      chk("pulse_width", wide_err, 0);
      chk("finish_outputs", fin_bad, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
